axi_rdata_router: RTL and testbench

- Parametrised successor to the fixed 3-slave / 2-master AXI R-channel mux. Routes read-data beats from NUM_S slave R channels to NUM_M master R channels.
- Fair round-robin arbitration among slaves. Burst lock is held until the RLAST handshake.
- Destination master is taken from the slave-side RID. Beats addressed to a nonexistent master are dropped and flagged.
- Sits inside the AXI interconnect, beside the AR/AW/W/B channel blocks.

---
 rtl/axi_rdata_router.sv | 153 +++++++++++++++
 tb/tb_axi_rdata_router.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rdata_router.sv
// rtl/axi_rdata_router.sv - parametrised AXI R-channel router with round-robin burst arbitration
//
// Routes read-data beats from NUM_S slave R channels to NUM_M master R channels.
// A slave is picked round-robin from rr_ptr and keeps the path until its RLAST
// handshake. The destination master comes from RID bits [ID_BITS +: MIDX_W].
// Beats whose destination master does not exist are sunk, and decerr pulses
// one cycle later.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   RID_S/RDATA_S/RRESP_S/RLAST_S slave-side R payload, slave i at slice i
//   RVALID_S / RREADY_S           slave-side handshake
//   RID_M/RDATA_M/RRESP_M/RLAST_M routed payload, broadcast to all masters
//   RVALID_M / RREADY_M           per-master handshake (RVALID_M one-hot or zero)
//   busy                          a burst lock is held
//   decerr                        registered pulse after each dropped beat
module axi_rdata_router #(
    parameter int NUM_S     = 3,
    parameter int NUM_M     = 2,
    parameter int ID_BITS   = 4,
    parameter int IDS_BITS  = 8,
    parameter int DATA_BITS = 32,
    localparam int MIDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1,
    localparam int SW       = $clog2(NUM_S)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_S*IDS_BITS-1:0]  RID_S,
    input  logic [NUM_S*DATA_BITS-1:0] RDATA_S,
    input  logic [NUM_S*2-1:0]         RRESP_S,
    input  logic [NUM_S-1:0]           RLAST_S,
    input  logic [NUM_S-1:0]           RVALID_S,
    output logic [NUM_S-1:0]           RREADY_S,
    output logic [ID_BITS-1:0]         RID_M,
    output logic [DATA_BITS-1:0]       RDATA_M,
    output logic [1:0]                 RRESP_M,
    output logic                       RLAST_M,
    output logic [NUM_M-1:0]           RVALID_M,
    input  logic [NUM_M-1:0]           RREADY_M,
    output logic                       busy,
    output logic                       decerr
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     gnt_q, gnt_d;
    logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              decerr_q, decerr_d;

    logic [SW-1:0]     cur;
    logic [SW-1:0]     cur_next;
    logic              found;
    logic [MIDX_W-1:0] dest;
    logic              dest_ok;
    logic              hs;
    int                idx;

    // Grant selection: a held lock wins outright; otherwise scan from rr_ptr.
    always_comb begin
        found = 1'b0;
        cur   = gnt_q;
        idx   = 0;
        if (state_q == LOCKED) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_S; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_S) begin
                    idx = idx - NUM_S;
                end
                if (!found && RVALID_S[idx]) begin
                    found = 1'b1;
                    cur   = SW'(idx);
                end
            end
        end
    end

    // RID bits above ID_BITS+MIDX_W never reach the decode.
    assign dest     = RID_S[int'(cur)*IDS_BITS + ID_BITS +: MIDX_W];
    assign dest_ok  = int'(dest) < NUM_M;
    assign cur_next = (cur == SW'(NUM_S - 1)) ? '0 : cur + SW'(1);

    // Zero-latency routing; handshakes are forced off while reset is held.
    always_comb begin
        RREADY_S = '0;
        RVALID_M = '0;
        RID_M    = '0;
        RDATA_M  = '0;
        RRESP_M  = '0;
        RLAST_M  = 1'b0;
        if (found) begin
            RID_M   = RID_S[int'(cur)*IDS_BITS +: ID_BITS];
            RDATA_M = RDATA_S[int'(cur)*DATA_BITS +: DATA_BITS];
            RRESP_M = RRESP_S[int'(cur)*2 +: 2];
            RLAST_M = RLAST_S[cur];
            if (rst) begin
                if (dest_ok) begin
                    RVALID_M[dest] = RVALID_S[cur];
                    RREADY_S[cur]  = RVALID_S[cur] & RREADY_M[dest];
                end else begin
                    // Decode error: accept the beat so the slave can drain.
                    RREADY_S[cur] = RVALID_S[cur];
                end
            end
        end
    end

    assign hs = found & RVALID_S[cur] & RREADY_S[cur];

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        decerr_d = hs & ~dest_ok;
        if (state_q == IDLE) begin
            if (found) begin
                if (hs && RLAST_S[cur]) begin
                    rr_ptr_d = cur_next;
                end else begin
                    // Includes a valid stalled by the master: AXI keeps it
                    // asserted, so the path is locked now.
                    state_d = LOCKED;
                    gnt_d   = cur;
                end
            end
        end else begin
            if (hs && RLAST_S[cur]) begin
                state_d  = IDLE;
                rr_ptr_d = cur_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            decerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            decerr_q <= decerr_d;
        end
    end

    assign busy   = (state_q == LOCKED);
    assign decerr = decerr_q;

endmodule

// File: tb/tb_axi_rdata_router.sv
// tb/tb_axi_rdata_router.sv - directed self-checking bench for axi_rdata_router
module tb_axi_rdata_router;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Instance A: NUM_S=3, NUM_M=2
    logic [23:0] a_rid_s;
    logic [95:0] a_rdata_s;
    logic [5:0]  a_rresp_s;
    logic [2:0]  a_rlast_s, a_rvalid_s, a_rready_s;
    logic [3:0]  a_rid_m;
    logic [31:0] a_rdata_m;
    logic [1:0]  a_rresp_m;
    logic        a_rlast_m;
    logic [1:0]  a_rvalid_m, a_rready_m;
    logic        a_busy, a_decerr;

    // Instance B: NUM_S=8, NUM_M=3 (dest 3 is a decode error)
    logic [63:0]  b_rid_s;
    logic [255:0] b_rdata_s;
    logic [15:0]  b_rresp_s;
    logic [7:0]   b_rlast_s, b_rvalid_s, b_rready_s;
    logic [3:0]   b_rid_m;
    logic [31:0]  b_rdata_m;
    logic [1:0]   b_rresp_m;
    logic         b_rlast_m;
    logic [2:0]   b_rvalid_m, b_rready_m;
    logic         b_busy, b_decerr;

    axi_rdata_router #(.NUM_S(3), .NUM_M(2)) u_a (
        .clk(clk), .rst(rstn),
        .RID_S(a_rid_s), .RDATA_S(a_rdata_s), .RRESP_S(a_rresp_s), .RLAST_S(a_rlast_s),
        .RVALID_S(a_rvalid_s), .RREADY_S(a_rready_s),
        .RID_M(a_rid_m), .RDATA_M(a_rdata_m), .RRESP_M(a_rresp_m), .RLAST_M(a_rlast_m),
        .RVALID_M(a_rvalid_m), .RREADY_M(a_rready_m),
        .busy(a_busy), .decerr(a_decerr)
    );

    axi_rdata_router #(.NUM_S(8), .NUM_M(3)) u_b (
        .clk(clk), .rst(rstn),
        .RID_S(b_rid_s), .RDATA_S(b_rdata_s), .RRESP_S(b_rresp_s), .RLAST_S(b_rlast_s),
        .RVALID_S(b_rvalid_s), .RREADY_S(b_rready_s),
        .RID_M(b_rid_m), .RDATA_M(b_rdata_m), .RRESP_M(b_rresp_m), .RLAST_M(b_rlast_m),
        .RVALID_M(b_rvalid_m), .RREADY_M(b_rready_m),
        .busy(b_busy), .decerr(b_decerr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic probe;
        @(negedge clk);
    endtask

    task automatic a_set(input int i, input logic [7:0] rid, input logic [31:0] data,
                         input logic last, input logic vld);
        a_rid_s[i*8 +: 8]     = rid;
        a_rdata_s[i*32 +: 32] = data;
        a_rresp_s[i*2 +: 2]   = 2'(i);
        a_rlast_s[i]          = last;
        a_rvalid_s[i]         = vld;
    endtask

    task automatic b_set(input int i, input logic [7:0] rid, input logic [31:0] data,
                         input logic last, input logic vld);
        b_rid_s[i*8 +: 8]     = rid;
        b_rdata_s[i*32 +: 32] = data;
        b_rresp_s[i*2 +: 2]   = 2'(i);
        b_rlast_s[i]          = last;
        b_rvalid_s[i]         = vld;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        a_set(0, 8'h00, 32'h11, 1'b1, 1'b1);
        tick;
        probe;
        n_total++; if (a_rready_s !== 3'b000) $display("FAIL rst_rready_s got %b exp 000", a_rready_s); else n_pass++;
        n_total++; if (a_rvalid_m !== 2'b00) $display("FAIL rst_rvalid_m got %b exp 00", a_rvalid_m); else n_pass++;
        tick;
        rstn = 1'b1;
        a_rvalid_s = '0;
        probe;
        n_total++; if (a_busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", a_busy); else n_pass++;
        n_total++; if (a_decerr !== 1'b0) $display("FAIL rst_decerr got %b exp 0", a_decerr); else n_pass++;
        n_total++; if (a_rdata_m !== 32'h0) $display("FAIL rst_idle_rdata got %h exp 0", a_rdata_m); else n_pass++;
        n_total++; if (b_busy !== 1'b0) $display("FAIL rst_b_busy got %b exp 0", b_busy); else n_pass++;
        tick;
    endtask

    task automatic test_burst;
        a_rready_m = 2'b10;
        for (int k = 0; k < 4; k++) begin
            a_set(1, 8'h13, 32'hA000_0000 + k, (k == 3), 1'b1);
            probe;
            n_total++; if (a_rvalid_m !== 2'b10) $display("FAIL burst_rvalid_m k=%0d got %b exp 10", k, a_rvalid_m); else n_pass++;
            n_total++; if (a_rid_m !== 4'h3) $display("FAIL burst_rid_m k=%0d got %h exp 3", k, a_rid_m); else n_pass++;
            n_total++; if (a_rdata_m !== 32'hA000_0000 + k) $display("FAIL burst_rdata k=%0d got %h", k, a_rdata_m); else n_pass++;
            n_total++; if (a_rresp_m !== 2'd1) $display("FAIL burst_rresp k=%0d got %0d exp 1", k, a_rresp_m); else n_pass++;
            n_total++; if (a_rready_s !== 3'b010) $display("FAIL burst_rready_s k=%0d got %b exp 010", k, a_rready_s); else n_pass++;
            n_total++; if (a_busy !== (k != 0)) $display("FAIL burst_busy k=%0d got %b exp %b", k, a_busy, (k != 0)); else n_pass++;
            n_total++; if (a_rlast_m !== (k == 3)) $display("FAIL burst_rlast k=%0d got %b", k, a_rlast_m); else n_pass++;
            tick;
        end
        a_rvalid_s = '0;
        probe;
        n_total++; if (a_busy !== 1'b0) $display("FAIL burst_release_busy got %b exp 0", a_busy); else n_pass++;
        tick;
    endtask

    // rr_ptr is 2 after the S1 burst, then 1 after the first pair.
    task automatic test_round_robin;
        logic [2:0] exp_first [2];
        exp_first[0] = 3'b100;
        exp_first[1] = 3'b100;
        a_rready_m = 2'b01;
        for (int r = 0; r < 2; r++) begin
            a_set(0, 8'h00, 32'hB0 + 32'(r*16), 1'b1, 1'b1);
            a_set(2, 8'h02, 32'hB2 + 32'(r*16), 1'b1, 1'b1);
            probe;
            n_total++; if (a_rready_s !== exp_first[r]) $display("FAIL rr%0d_first got %b exp %b", r, a_rready_s, exp_first[r]); else n_pass++;
            n_total++; if (a_rdata_m !== 32'hB2 + 32'(r*16)) $display("FAIL rr%0d_first_data got %h", r, a_rdata_m); else n_pass++;
            n_total++; if (a_rvalid_m !== 2'b01) $display("FAIL rr%0d_rvalid_m got %b exp 01", r, a_rvalid_m); else n_pass++;
            tick;
            a_rvalid_s[2] = 1'b0;
            probe;
            n_total++; if (a_rready_s !== 3'b001) $display("FAIL rr%0d_second got %b exp 001", r, a_rready_s); else n_pass++;
            tick;
            a_rvalid_s[0] = 1'b0;
        end
    endtask

    // rr_ptr is 1; S0 is the only requester, then S1 arrives during the stall.
    task automatic test_lock_stall;
        a_rready_m = 2'b01;
        for (int k = 0; k < 2; k++) begin
            a_set(0, 8'h00, 32'hD0 + k, 1'b0, 1'b1);
            probe;
            n_total++; if (a_rready_s !== 3'b001) $display("FAIL lock_beat%0d got %b exp 001", k, a_rready_s); else n_pass++;
            tick;
        end
        a_set(0, 8'h00, 32'hD2, 1'b0, 1'b1);
        a_set(1, 8'h11, 32'hE1, 1'b1, 1'b1);
        a_rready_m = 2'b10;
        for (int c = 0; c < 3; c++) begin
            probe;
            n_total++; if (a_rready_s !== 3'b000) $display("FAIL stall%0d_rready_s got %b exp 000", c, a_rready_s); else n_pass++;
            n_total++; if (a_rdata_m !== 32'hD2) $display("FAIL stall%0d_rdata got %h exp d2", c, a_rdata_m); else n_pass++;
            n_total++; if (a_rvalid_m !== 2'b01) $display("FAIL stall%0d_rvalid_m got %b exp 01", c, a_rvalid_m); else n_pass++;
            n_total++; if (a_busy !== 1'b1) $display("FAIL stall%0d_busy got %b exp 1", c, a_busy); else n_pass++;
            tick;
        end
        a_rready_m = 2'b11;
        probe;
        n_total++; if (a_rready_s !== 3'b001) $display("FAIL lock_beat2 got %b exp 001", a_rready_s); else n_pass++;
        tick;
        a_set(0, 8'h00, 32'hD3, 1'b1, 1'b1);
        probe;
        n_total++; if (a_rready_s !== 3'b001) $display("FAIL lock_beat3 got %b exp 001", a_rready_s); else n_pass++;
        n_total++; if (a_rlast_m !== 1'b1) $display("FAIL lock_rlast got %b exp 1", a_rlast_m); else n_pass++;
        tick;
        a_rvalid_s[0] = 1'b0;
        probe;
        n_total++; if (a_rready_s !== 3'b010) $display("FAIL b2b_rready_s got %b exp 010", a_rready_s); else n_pass++;
        n_total++; if (a_rvalid_m !== 2'b10) $display("FAIL b2b_rvalid_m got %b exp 10", a_rvalid_m); else n_pass++;
        n_total++; if (a_rdata_m !== 32'hE1) $display("FAIL b2b_rdata got %h exp e1", a_rdata_m); else n_pass++;
        n_total++; if (a_busy !== 1'b0) $display("FAIL b2b_busy got %b exp 0", a_busy); else n_pass++;
        tick;
        a_rvalid_s[1] = 1'b0;
    endtask

    // rr_ptr is 2 here, so without a reset S2 would win the final race.
    task automatic test_reset_mid_burst;
        a_rready_m = 2'b01;
        for (int k = 0; k < 2; k++) begin
            a_set(1, 8'h01, 32'hF0 + k, 1'b0, 1'b1);
            probe;
            n_total++; if (a_rready_s !== 3'b010) $display("FAIL mid_beat%0d got %b exp 010", k, a_rready_s); else n_pass++;
            tick;
        end
        a_set(1, 8'h01, 32'hF2, 1'b0, 1'b1);
        rstn = 1'b0;
        probe;
        n_total++; if (a_rready_s !== 3'b000) $display("FAIL mid_rst_rready_s got %b exp 000", a_rready_s); else n_pass++;
        n_total++; if (a_rvalid_m !== 2'b00) $display("FAIL mid_rst_rvalid_m got %b exp 00", a_rvalid_m); else n_pass++;
        tick;
        rstn = 1'b1;
        a_rvalid_s = '0;
        probe;
        n_total++; if (a_busy !== 1'b0) $display("FAIL mid_after_busy got %b exp 0", a_busy); else n_pass++;
        n_total++; if (a_rvalid_m !== 2'b00) $display("FAIL mid_after_rvalid_m got %b exp 00", a_rvalid_m); else n_pass++;
        tick;
        for (int i = 0; i < 3; i++) a_set(i, 8'h00, 32'h90 + i, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            probe;
            n_total++; if (a_rready_s !== 3'(1 << i)) $display("FAIL restart%0d got %b exp %b", i, a_rready_s, 3'(1 << i)); else n_pass++;
            tick;
            a_rvalid_s[i] = 1'b0;
        end
    endtask

    task automatic test_decerr;
        b_rready_m = 3'b111;
        b_set(2, 8'h3A, 32'h5A0, 1'b0, 1'b1);
        probe;
        n_total++; if (b_rvalid_m !== 3'b000) $display("FAIL dec0_rvalid_m got %b exp 000", b_rvalid_m); else n_pass++;
        n_total++; if (b_rready_s !== 8'h04) $display("FAIL dec0_rready_s got %h exp 04", b_rready_s); else n_pass++;
        n_total++; if (b_decerr !== 1'b0) $display("FAIL dec0_decerr got %b exp 0", b_decerr); else n_pass++;
        n_total++; if (b_rid_m !== 4'hA) $display("FAIL dec0_rid_m got %h exp a", b_rid_m); else n_pass++;
        tick;
        b_set(2, 8'h3A, 32'h5A1, 1'b1, 1'b1);
        probe;
        n_total++; if (b_rvalid_m !== 3'b000) $display("FAIL dec1_rvalid_m got %b exp 000", b_rvalid_m); else n_pass++;
        n_total++; if (b_rready_s !== 8'h04) $display("FAIL dec1_rready_s got %h exp 04", b_rready_s); else n_pass++;
        n_total++; if (b_decerr !== 1'b1) $display("FAIL dec1_decerr got %b exp 1", b_decerr); else n_pass++;
        n_total++; if (b_busy !== 1'b1) $display("FAIL dec1_busy got %b exp 1", b_busy); else n_pass++;
        tick;
        b_rvalid_s[2] = 1'b0;
        probe;
        n_total++; if (b_decerr !== 1'b1) $display("FAIL dec2_decerr got %b exp 1", b_decerr); else n_pass++;
        n_total++; if (b_busy !== 1'b0) $display("FAIL dec2_busy got %b exp 0", b_busy); else n_pass++;
        tick;
        probe;
        n_total++; if (b_decerr !== 1'b0) $display("FAIL dec3_decerr got %b exp 0", b_decerr); else n_pass++;
        tick;
    endtask

    // rr_ptr is 3 after the S2 decode-error burst; all eight request at once.
    // RID bits [7:6] are set to show they are ignored.
    task automatic test_wrap;
        int e;
        b_rready_m = 3'b111;
        for (int i = 0; i < 8; i++) b_set(i, {2'b11, 2'(i % 3), 4'(i)}, 32'h700 + i, 1'b1, 1'b1);
        for (int n = 0; n < 8; n++) begin
            e = (3 + n) % 8;
            probe;
            n_total++; if (b_rready_s !== 8'(1 << e)) $display("FAIL wrap%0d_rready_s got %b exp %b", n, b_rready_s, 8'(1 << e)); else n_pass++;
            n_total++; if (b_rvalid_m !== 3'(1 << (e % 3))) $display("FAIL wrap%0d_rvalid_m got %b exp %b", n, b_rvalid_m, 3'(1 << (e % 3))); else n_pass++;
            n_total++; if (b_rdata_m !== 32'h700 + e) $display("FAIL wrap%0d_rdata got %h exp %h", n, b_rdata_m, 32'h700 + e); else n_pass++;
            n_total++; if (b_rid_m !== 4'(e)) $display("FAIL wrap%0d_rid_m got %h exp %h", n, b_rid_m, 4'(e)); else n_pass++;
            tick;
            b_rvalid_s[e] = 1'b0;
        end
        probe;
        n_total++; if (b_rready_s !== 8'h00) $display("FAIL wrap_done_rready_s got %h exp 00", b_rready_s); else n_pass++;
        tick;
    endtask

    initial begin
        rstn       = 1'b0;
        a_rid_s    = '0; a_rdata_s = '0; a_rresp_s = '0; a_rlast_s = '0; a_rvalid_s = '0; a_rready_m = '0;
        b_rid_s    = '0; b_rdata_s = '0; b_rresp_s = '0; b_rlast_s = '0; b_rvalid_s = '0; b_rready_m = '0;
        tick;
        test_reset;
        test_burst;
        test_round_robin;
        test_lock_stall;
        test_reset_mid_burst;
        test_decerr;
        test_wrap;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
